// File: rtl/sodor_dmem_requester_if.sv
// Bundle of core command, completion and dmem request/response signals for sodor_dmem_requester.
// The requester uses the slave modport; the core/memory side uses master.
interface sodor_dmem_requester_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_typ;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_data;
  logic        dmem_req_valid;
  logic        dmem_req_write_en;
  logic [2:0]  dmem_req_bits_typ;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_typ,
    input  dmem_resp_valid, dmem_resp_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output dmem_req_addr, dmem_req_data, dmem_req_valid, dmem_req_write_en, dmem_req_bits_typ
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_typ,
    output dmem_resp_valid, dmem_resp_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  dmem_req_addr, dmem_req_data, dmem_req_valid, dmem_req_write_en, dmem_req_bits_typ
  );
endinterface

// File: rtl/sodor_dmem_requester.sv
// Single-outstanding load/store requester with lane steering, alignment checks and load extension.
// Optional read timeout enabled by defining DMEM_REQ_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module sodor_dmem_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  sodor_dmem_requester_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_W  = 3'd3;
  localparam logic [2:0] TYP_BU = 3'd5;
  localparam logic [2:0] TYP_HU = 3'd6;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [2:0]  typ_q;
  logic        write_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_data_q;
  logic        req_valid_q;
  logic        req_we_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
`ifdef DMEM_REQ_TIMEOUT_EN
  logic [7:0]  cnt_q;
`endif

  logic        cmd_bad;
  logic [31:0] wdata_steer;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      TYP_B:   extract = {{24{b[7]}}, b};
      TYP_BU:  extract = {24'd0, b};
      TYP_H:   extract = {{16{h[15]}}, h};
      TYP_HU:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmd_bad = 1'b0;
    if (!(bus.cmd_typ inside {TYP_B, TYP_H, TYP_W, TYP_BU, TYP_HU})) cmd_bad = 1'b1;
    if ((bus.cmd_typ inside {TYP_H, TYP_HU}) && bus.cmd_addr[0]) cmd_bad = 1'b1;
    if ((bus.cmd_typ == TYP_W) && (bus.cmd_addr[1:0] != 2'b00)) cmd_bad = 1'b1;

    wdata_steer = bus.cmd_wdata;
    case (bus.cmd_typ)
      TYP_B, TYP_BU: wdata_steer = {4{bus.cmd_wdata[7:0]}};
      TYP_H, TYP_HU: wdata_steer = {2{bus.cmd_wdata[15:0]}};
      default:       wdata_steer = bus.cmd_wdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= 2'd0;
      typ_q       <= 3'd0;
      write_q     <= 1'b0;
      req_addr_q  <= 32'd0;
      req_data_q  <= 32'd0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
`ifdef DMEM_REQ_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            off_q      <= bus.cmd_addr[1:0];
            typ_q      <= bus.cmd_typ;
            write_q    <= bus.cmd_write;
            req_addr_q <= {bus.cmd_addr[31:2], 2'b00};
            req_data_q <= wdata_steer;
            if (cmd_bad) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'd0;
            end else begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_we_q    <= bus.cmd_write;
            end
          end
        end
        REQ: begin
          req_valid_q <= 1'b0;
          req_we_q    <= 1'b0;
          if (write_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
          end else begin
            state_q <= WAIT;
`ifdef DMEM_REQ_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        WAIT: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (bus.dmem_resp_valid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= extract(bus.dmem_resp_data, off_q, typ_q);
          end
`ifdef DMEM_REQ_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 32'd0;
            cnt_q       <= cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready         = (state_q == IDLE);
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_err           = rsp_err_q;
  assign bus.dmem_req_addr     = req_addr_q;
  assign bus.dmem_req_data     = req_data_q;
  assign bus.dmem_req_valid    = req_valid_q;
  assign bus.dmem_req_write_en = req_we_q;
  assign bus.dmem_req_bits_typ = typ_q;

endmodule

// File: tb/tb_sodor_dmem_requester.sv
// Self-checking bench for sodor_dmem_requester: directed plan cases plus randomized traffic
// compared against a behavioural model of extension, lane steering and cycle timing.
module tb_sodor_dmem_requester;

  localparam int unsigned TB_TIMEOUT = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  sodor_dmem_requester_if bus ();

  sodor_dmem_requester #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [2:0] t, input logic [31:0] a);
    int unsigned sz;
    if (!(t == 1 || t == 2 || t == 3 || t == 5 || t == 6)) return 1'b0;
    sz = (t == 3) ? 4 : ((t == 2 || t == 6) ? 2 : 1);
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] t);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (t)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return b;
      3'd6:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] wd, input logic [2:0] t);
    case (t)
      3'd1, 3'd5: return (wd & 32'hFF) * 32'h0101_0101;
      3'd2, 3'd6: return (wd & 32'hFFFF) * 32'h0001_0001;
      default:    return wd;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] t, input int dly, input logic [31:0] word, input bit stray);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_typ   = t;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    check("cmd_ready_busy", bus.cmd_ready, 0);
    if (!model_legal(t, a)) begin
      check("err_rsp_valid", bus.rsp_valid, 1);
      check("err_rsp_err", bus.rsp_err, 1);
      check("err_rsp_data", bus.rsp_data, 0);
      check("err_no_req", bus.dmem_req_valid, 0);
      @(negedge clk);
      check("err_rsp_once", bus.rsp_valid, 0);
      check("err_no_req_after", bus.dmem_req_valid, 0);
    end else begin
      check("req_valid", bus.dmem_req_valid, 1);
      check("req_we", bus.dmem_req_write_en, wr);
      check("req_addr", bus.dmem_req_addr, a & 32'hFFFF_FFFC);
      check("req_typ", bus.dmem_req_bits_typ, t);
      check("rsp_quiet_req", bus.rsp_valid, 0);
      if (wr) check("req_data", bus.dmem_req_data, model_store(wd, t));
      if (!wr && stray) begin
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_data  = ~word;
      end
      @(negedge clk);
      bus.dmem_resp_valid = 1'b0;
      check("req_one_cycle", bus.dmem_req_valid, 0);
      check("req_we_default", bus.dmem_req_write_en, 0);
      if (wr) begin
        check("st_rsp_valid", bus.rsp_valid, 1);
        check("st_rsp_err", bus.rsp_err, 0);
        check("st_rsp_data", bus.rsp_data, 0);
      end else begin
        for (int i = 0; i <= dly; i++) begin
          if (i > 0) @(negedge clk);
          check("ld_wait_quiet", bus.rsp_valid, 0);
          check("ld_wait_busy", bus.cmd_ready, 0);
          if (i == dly) begin
            bus.dmem_resp_valid = 1'b1;
            bus.dmem_resp_data  = word;
          end
        end
        @(negedge clk);
        if (stray) bus.dmem_resp_data = $urandom;
        else bus.dmem_resp_valid = 1'b0;
        check("ld_rsp_valid", bus.rsp_valid, 1);
        check("ld_rsp_err", bus.rsp_err, 0);
        check("ld_rsp_data", bus.rsp_data, model_load(word, a, t));
      end
      @(negedge clk);
      bus.dmem_resp_valid = 1'b0;
      check("rsp_one_cycle", bus.rsp_valid, 0);
    end
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    bit          wr;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_typ   = 3'd0;
    bus.dmem_resp_valid = 1'b0;
    bus.dmem_resp_data  = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_req_valid", bus.dmem_req_valid, 0);
    check("rst_req_we", bus.dmem_req_write_en, 0);
    check("rst_req_addr", bus.dmem_req_addr, 0);
    check("rst_req_data", bus.dmem_req_data, 0);
    check("rst_req_typ", bus.dmem_req_bits_typ, 0);

    txn(1'b0, 32'h100, 32'h0, 3'd3, 0, 32'h8000_00F0, 1'b0);
    txn(1'b0, 32'h103, 32'h0, 3'd1, 1, 32'h80FF_1234, 1'b0);
    txn(1'b0, 32'h103, 32'h0, 3'd5, 0, 32'h80FF_1234, 1'b1);
    txn(1'b0, 32'h102, 32'h0, 3'd2, 2, 32'h80FF_1234, 1'b0);
    txn(1'b1, 32'h206, 32'hAAAA_BEEF, 3'd2, 0, 32'h0, 1'b0);
    txn(1'b0, 32'h102, 32'h0, 3'd3, 0, 32'h0, 1'b0);
    txn(1'b1, 32'h301, 32'h1234_5678, 3'd2, 0, 32'h0, 1'b0);
    txn(1'b0, 32'h300, 32'h0, 3'd4, 0, 32'h0, 1'b0);
    txn(1'b0, 32'h105, 32'h0, 3'd6, 3, 32'hC3A5_7E01, 1'b0);

    // No response to a word load.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h80;
    bus.cmd_typ   = 3'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
`ifdef DMEM_REQ_TIMEOUT_EN
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      @(negedge clk);
      check("to_wait_quiet", bus.rsp_valid, 0);
    end
    @(negedge clk);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    check("to_idle", bus.cmd_ready, 1);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("no_to_quiet", bus.rsp_valid, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("no_to_recover", bus.cmd_ready, 1);
`endif

    // Reset while waiting for a load, then a late response.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h44;
    bus.cmd_typ   = 3'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.dmem_resp_valid = 1'b0;
    check("mid_rst_ready", bus.cmd_ready, 1);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rsp_data", bus.rsp_data, 0);
    check("mid_rst_rsp_err", bus.rsp_err, 0);
    check("mid_rst_req_valid", bus.dmem_req_valid, 0);
    check("mid_rst_req_addr", bus.dmem_req_addr, 0);
    check("mid_rst_req_data", bus.dmem_req_data, 0);
    check("mid_rst_req_typ", bus.dmem_req_bits_typ, 0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_rsp", bus.rsp_valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      t  = 3'($urandom_range(0, 7));
      if (wr && (t == 3'd5 || t == 3'd6)) t = 3'($urandom_range(1, 3));
      a  = $urandom_range(0, 32'hFFFF);
      txn(wr, a, $urandom, t, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
